// File: rtl/led_blinker_pkg.sv
// Shared types and helpers for the multi-channel LED blinker.
//   mode_t    : per-channel operating mode (2 bits)
//   state_t   : per-channel phase FSM state, explicit legacy encodings
//   tick_div  : clk cycles per phase-counter tick
package led_blinker_pkg;

    localparam int unsigned MODE_W  = 2;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_PH_HI = 2'd1,
        ST_PH_LO = 2'd2
    } state_t;

    function automatic int unsigned tick_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/led_blinker_multi_tick_prescaler.sv
// tick_prescaler: free-running divider producing a one-clk tick every
// CLK_HZ/TICK_HZ cycles (count 0..DIV-1, tick while count == DIV-1).
// Ports:
//   clk         in  system clock
//   async_reset in  synchronous active-low reset
//   tick        out one-cycle strobe
module tick_prescaler
    import led_blinker_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1_000
) (
    input  logic clk,
    input  logic async_reset,
    output logic tick
);

    localparam int unsigned DIV   = tick_div(CLK_HZ, TICK_HZ);
    localparam int unsigned DIV_W = $clog2(DIV);
    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!async_reset) cnt_q <= '0;
        else              cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_blinker_multi.sv
// led_blinker_multi: N-channel LED blinker. A rising edge on toggle[i]
// flips the enable of channel i; each channel runs its own phase FSM and
// tick counter in the selected mode (OFF/ON/BLINK/ONESHOT) with a runtime
// half-period. One shared tick prescaler.
// Ports:
//   clk          in  system clock
//   async_reset  in  synchronous active-low reset
//   toggle       in  [CHANNELS] enable-toggle requests (rising edge)
//   mode         in  [2*CHANNELS] channel i mode at [2i+1:2i]
//   half_period  in  [PERIOD_W*CHANNELS] channel i half-period in ticks
//   blinking     out [CHANNELS] registered LED drive
//   active       out [CHANNELS] registered enable state
// Configuration macro: LED_BLINKER_SYNC_TOGGLE_EN adds a 2-flop
// synchroniser on toggle (toggle->active latency 3 cycles instead of 1).
module led_blinker_multi
    import led_blinker_pkg::*;
#(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned TICK_HZ  = 1_000,
    parameter int unsigned PERIOD_W = 12
) (
    input  logic                         clk,
    input  logic                         async_reset,
    input  logic [CHANNELS-1:0]          toggle,
    input  logic [2*CHANNELS-1:0]        mode,
    input  logic [PERIOD_W*CHANNELS-1:0] half_period,
    output logic [CHANNELS-1:0]          blinking,
    output logic [CHANNELS-1:0]          active
);

    logic tick;

    tick_prescaler #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_prescaler (
        .clk        (clk),
        .async_reset(async_reset),
        .tick       (tick)
    );

    logic [CHANNELS-1:0] tog_in;

`ifdef LED_BLINKER_SYNC_TOGGLE_EN
    logic [CHANNELS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

    always_comb begin
        sync1_d = toggle;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!async_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign tog_in = sync2_q;
`else
    assign tog_in = toggle;
`endif

    // Edge register resets high so a line held high through reset is not
    // taken as a fresh press once reset releases.
    logic [CHANNELS-1:0] toggle_q, toggle_d, rise;

    always_comb begin
        toggle_d = tog_in;
    end

    always_ff @(posedge clk) begin
        if (!async_reset) toggle_q <= '1;
        else              toggle_q <= toggle_d;
    end

    assign rise = tog_in & ~toggle_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        mode_t               m;
        logic [PERIOD_W-1:0] hp_in, hp_clamp;
        state_t              state_q, state_d;
        mode_t               mode_q;
        logic [PERIOD_W-1:0] cnt_q, cnt_d, hp_q, hp_d;
        logic                act_q, act_d, blink_q, blink_d;
        logic                en, done, last;

        assign m        = mode_t'(mode[2*i +: 2]);
        assign hp_in    = half_period[PERIOD_W*i +: PERIOD_W];
        assign hp_clamp = (hp_in == '0) ? PERIOD_W'(1) : hp_in;
        assign last     = tick && (cnt_q == hp_q - PERIOD_W'(1));

        // en is the enable after this edge's toggle; a toggle rise on the
        // same edge as ONESHOT completion therefore still ends disabled.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            hp_d    = hp_q;
            done    = 1'b0;
            en      = act_q ^ rise[i];
            if (!en) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (m != MODE_OFF) begin
                            state_d = ST_PH_HI;
                            cnt_d   = '0;
                            hp_d    = hp_clamp;
                        end
                    end
                    ST_PH_HI, ST_PH_LO: begin
                        if (m == MODE_OFF) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else if (m != mode_q) begin
                            state_d = ST_PH_HI;
                            cnt_d   = '0;
                            hp_d    = hp_clamp;
                        end else if (state_q == ST_PH_HI) begin
                            if (m != MODE_ON && tick) begin
                                if (last) begin
                                    cnt_d = '0;
                                    if (m == MODE_BLINK) begin
                                        state_d = ST_PH_LO;
                                    end else begin
                                        state_d = ST_IDLE;
                                        done    = 1'b1;
                                    end
                                end else begin
                                    cnt_d = cnt_q + PERIOD_W'(1);
                                end
                            end
                        end else if (tick) begin
                            if (last) begin
                                state_d = ST_PH_HI;
                                cnt_d   = '0;
                                hp_d    = hp_clamp;
                            end else begin
                                cnt_d = cnt_q + PERIOD_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
            act_d   = en & ~done;
            blink_d = (state_d == ST_PH_HI);
        end

        always_ff @(posedge clk) begin
            if (!async_reset) begin
                state_q <= ST_IDLE;
                mode_q  <= MODE_OFF;
                cnt_q   <= '0;
                hp_q    <= PERIOD_W'(1);
                act_q   <= 1'b0;
                blink_q <= 1'b0;
            end else begin
                state_q <= state_d;
                mode_q  <= m;
                cnt_q   <= cnt_d;
                hp_q    <= hp_d;
                act_q   <= act_d;
                blink_q <= blink_d;
            end
        end

        assign blinking[i] = blink_q;
        assign active[i]   = act_q;
    end

endmodule
